// File: rtl/paddle_motion_pkg.sv
// Shared paddle/ball definitions: control encodings and motion FSM states.
package paddle_motion_pkg;

  localparam int unsigned CTRL_W   = 2;
  localparam int unsigned SPEED_W  = 4;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned HALF_W_W = 7;

  localparam logic [CTRL_W-1:0] CTRL_NONE  = 2'd0;
  localparam logic [CTRL_W-1:0] CTRL_LEFT  = 2'd1;
  localparam logic [CTRL_W-1:0] CTRL_RIGHT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE_L = 2'd1,
    ST_MOVE_R = 2'd2
  } paddle_state_e;

endpackage

// File: rtl/paddle_clamp.sv
// Combinational step-and-clamp of a paddle centre against its width-dependent limits.
module paddle_clamp
  import paddle_motion_pkg::*;
#(
  parameter int unsigned X_W         = 10,
  parameter int unsigned LEFT_BOUND  = 20,
  parameter int unsigned RIGHT_BOUND = 610
) (
  input  logic [X_W-1:0]      x,
  input  logic [HALF_W_W-1:0] half_w,
  input  logic [SPEED_W-1:0]  step,
  input  paddle_state_e       dir,
  output logic [X_W-1:0]      x_next,
  output logic                hit_edge,
  output logic                at_lo,
  output logic                at_hi
);

  localparam int unsigned XW1 = X_W + 1;

  logic [X_W:0] xw;
  logic [X_W:0] lo;
  logic [X_W:0] hi;
  logic [X_W:0] target;
  logic [X_W:0] res;

  // Limits, directional step (saturating at 0) and final clamp, all one bit wider than x.
  always_comb begin
    xw       = XW1'(x);
    lo       = XW1'(LEFT_BOUND) + XW1'(half_w);
    hi       = (XW1'(half_w) > XW1'(RIGHT_BOUND)) ? '0 : XW1'(RIGHT_BOUND) - XW1'(half_w);
    target   = xw;
    hit_edge = 1'b0;
    case (dir)
      ST_MOVE_L: begin
        target   = (XW1'(step) > xw) ? '0 : xw - XW1'(step);
        hit_edge = (target < lo);
      end
      ST_MOVE_R: begin
        target   = xw + XW1'(step);
        hit_edge = (target > hi);
      end
      default: ;
    endcase
    if (target < lo) begin
      res = lo;
    end else if (target > hi) begin
      res = hi;
    end else begin
      res = target;
    end
    x_next = X_W'(res);
    at_lo  = (res == lo);
    at_hi  = (res == hi);
  end

endmodule

// File: rtl/paddle_motion.sv
// Player paddle: accelerating left/right motion on frame ticks, clamped to the playfield.
module paddle_motion
  import paddle_motion_pkg::*;
#(
  parameter int unsigned X_W         = 10,
  parameter int unsigned LEFT_BOUND  = 20,
  parameter int unsigned RIGHT_BOUND = 610,
  parameter int unsigned RESET_X     = 295,
  parameter int unsigned MAX_SPEED   = 8,
  parameter int unsigned ACCEL_TICKS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [CTRL_W-1:0]   controls,
  input  logic [HALF_W_W-1:0] paddle_width,
  output logic [X_W-1:0]      paddle_x,
  output logic [SPEED_W-1:0]  speed,
  output logic                at_left,
  output logic                at_right
);

  if (LEFT_BOUND >= RIGHT_BOUND) begin : g_bad_bounds
    $error("paddle_motion: LEFT_BOUND must be below RIGHT_BOUND");
  end
  if (MAX_SPEED == 0 || MAX_SPEED > 15) begin : g_bad_speed
    $error("paddle_motion: MAX_SPEED must be in 1..15");
  end
  if (ACCEL_TICKS == 0 || ACCEL_TICKS > 255) begin : g_bad_accel
    $error("paddle_motion: ACCEL_TICKS must be in 1..255");
  end
  if (RIGHT_BOUND >= (2 ** X_W)) begin : g_bad_width
    $error("paddle_motion: RIGHT_BOUND does not fit in X_W bits");
  end

  // The tick that leaves IDLE counts as the first tick of sustained motion.
  localparam logic [CNT_W-1:0] ENTRY_CNT = (ACCEL_TICKS > 1) ? CNT_W'(1) : CNT_W'(0);

  paddle_state_e        state_q, state_d;
  logic [SPEED_W-1:0]   speed_q, spd_mv, speed_d;
  logic [CNT_W-1:0]     cnt_q, cnt_mv, cnt_d;
  logic [X_W-1:0]       x_q, x_d;
  logic                 at_left_q, at_right_q;
  logic                 hit_edge, at_lo, at_hi;

  // Motion FSM: next state, step size and acceleration counter before edge clamping.
  always_comb begin
    state_d = state_q;
    spd_mv  = speed_q;
    cnt_mv  = cnt_q;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (controls == CTRL_LEFT) begin
            state_d = ST_MOVE_L;
            spd_mv  = SPEED_W'(1);
            cnt_mv  = ENTRY_CNT;
          end else if (controls == CTRL_RIGHT) begin
            state_d = ST_MOVE_R;
            spd_mv  = SPEED_W'(1);
            cnt_mv  = ENTRY_CNT;
          end
        end
        ST_MOVE_L, ST_MOVE_R: begin
          if ((state_q == ST_MOVE_L && controls == CTRL_LEFT) ||
              (state_q == ST_MOVE_R && controls == CTRL_RIGHT)) begin
            if ((9'(cnt_q) + 9'd1) >= 9'(ACCEL_TICKS)) begin
              cnt_mv = '0;
              if (speed_q < SPEED_W'(MAX_SPEED)) begin
                spd_mv = speed_q + SPEED_W'(1);
              end
            end else begin
              cnt_mv = cnt_q + CNT_W'(1);
            end
          end else if (controls == CTRL_LEFT || controls == CTRL_RIGHT) begin
            state_d = (controls == CTRL_LEFT) ? ST_MOVE_L : ST_MOVE_R;
            spd_mv  = SPEED_W'(1);
            cnt_mv  = '0;
          end else begin
            state_d = ST_IDLE;
            spd_mv  = '0;
            cnt_mv  = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          spd_mv  = '0;
          cnt_mv  = '0;
        end
      endcase
    end
  end

  paddle_clamp #(
    .X_W         (X_W),
    .LEFT_BOUND  (LEFT_BOUND),
    .RIGHT_BOUND (RIGHT_BOUND)
  ) u_clamp (
    .x        (x_q),
    .half_w   (paddle_width),
    .step     (spd_mv),
    .dir      (state_d),
    .x_next   (x_d),
    .hit_edge (hit_edge),
    .at_lo    (at_lo),
    .at_hi    (at_hi)
  );

  // Running into an edge drops back to the slowest step without leaving the move state.
  always_comb begin
    speed_d = spd_mv;
    cnt_d   = cnt_mv;
    if (hit_edge) begin
      speed_d = SPEED_W'(1);
      cnt_d   = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Position, speed, counter and edge flags advance only on frame ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q        <= X_W'(RESET_X);
      speed_q    <= '0;
      cnt_q      <= '0;
      at_left_q  <= 1'b0;
      at_right_q <= 1'b0;
    end else if (tick) begin
      x_q        <= x_d;
      speed_q    <= speed_d;
      cnt_q      <= cnt_d;
      at_left_q  <= at_lo;
      at_right_q <= at_hi;
    end
  end

  assign paddle_x = x_q;
  assign speed    = speed_q;
  assign at_left  = at_left_q;
  assign at_right = at_right_q;

endmodule

// File: tb/tb_paddle_motion.sv
// Self-checking bench for paddle_motion: directed scenarios plus randomized run against a model.
module tb_paddle_motion;

  localparam int LB = 20;
  localparam int RB = 610;
  localparam int RX = 295;
  localparam int MS = 8;
  localparam int AT = 4;

  logic       clk;
  logic       rst;
  logic       tick;
  logic [1:0] controls;
  logic [6:0] paddle_width;
  logic [9:0] paddle_x;
  logic [3:0] speed;
  logic       at_left;
  logic       at_right;

  int checks;
  int fails;

  // Reference model: direction, run length since last (re)start, position, flags.
  int m_x;
  int m_dir;
  int m_run;
  int m_spd;
  bit m_al;
  bit m_ar;

  paddle_motion dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .controls     (controls),
    .paddle_width (paddle_width),
    .paddle_x     (paddle_x),
    .speed        (speed),
    .at_left      (at_left),
    .at_right     (at_right)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_x = RX; m_dir = 0; m_run = 0; m_spd = 0; m_al = 0; m_ar = 0;
  endtask

  // Speed follows the run length: 1 on the first tick, +1 every AT ticks, capped at MS.
  task automatic model_tick(input int c, input int w);
    int want, lo, hi, tgt, s;
    lo   = LB + w;
    hi   = RB - w;
    want = (c == 1) ? 1 : (c == 2) ? 2 : 0;
    if (want == 0) begin
      m_dir = 0; m_run = 0;
    end else if (m_dir == 0) begin
      m_dir = want; m_run = 1;
    end else if (m_dir != want) begin
      m_dir = want; m_run = 0;
    end else begin
      m_run = m_run + 1;
    end
    s = (m_dir == 0) ? 0 : 1 + m_run / AT;
    if (s > MS) s = MS;
    tgt = (m_dir == 1) ? m_x - s : (m_dir == 2) ? m_x + s : m_x;
    if ((m_dir == 1 && tgt < lo) || (m_dir == 2 && tgt > hi)) begin
      s = 1; m_run = 0;
    end
    m_spd = s;
    m_x   = (tgt < lo) ? lo : (tgt > hi) ? hi : tgt;
    m_al  = (m_x == lo);
    m_ar  = (m_x == hi);
  endtask

  task automatic cycle(input bit t, input int c, input int w);
    @(negedge clk);
    tick = t; controls = 2'(c); paddle_width = 7'(w);
    @(posedge clk);
    #1;
    if (t) model_tick(c, w);
    tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 model_reset();
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; tick = 0; controls = 0; paddle_width = 7'd20;
    #12;
    if ({paddle_x, speed, at_left, at_right} !== {10'd295, 4'd0, 1'b0, 1'b0}) begin
      $display("FAIL reset_state: x=%0d spd=%0d al=%0b ar=%0b want x=295 spd=0 al=0 ar=0",
               paddle_x, speed, at_left, at_right);
      fails++;
    end
    checks++;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) cycle(1, (i == 2) ? 3 : 0, 20);
    if ({paddle_x, speed, at_left, at_right} !== {10'd295, 4'd0, 1'b0, 1'b0}) begin
      $display("FAIL idle_ticks: x=%0d spd=%0d al=%0b ar=%0b want x=295 spd=0 al=0 ar=0",
               paddle_x, speed, at_left, at_right);
      fails++;
    end
    checks++;
  endtask

  task automatic test_accel();
    int exp_spd[12];
    exp_spd = '{1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 4};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(1, 2, 20);
      if (speed !== 4'(exp_spd[i])) begin
        $display("FAIL accel_speed[%0d]: got %0d want %0d", i, speed, exp_spd[i]);
        fails++;
      end
      checks++;
    end
    if (paddle_x !== 10'd322) begin
      $display("FAIL accel_pos: got %0d want 322", paddle_x);
      fails++;
    end
    checks++;
  endtask

  task automatic test_left_edge();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 2, 20);
    cycle(1, 0, 20);
    if (paddle_x !== 10'd300) begin
      $display("FAIL left_edge_start: got %0d want 300", paddle_x);
      fails++;
    end
    checks++;
    for (int i = 0; i < 80; i++) begin
      cycle(1, 1, 20);
      if (paddle_x < 10'd40) begin
        $display("FAIL left_edge_overrun[%0d]: got %0d want >=40", i, paddle_x);
        fails++;
      end
      checks++;
    end
    if ({paddle_x, speed, at_left, at_right} !== {10'd40, 4'd1, 1'b1, 1'b0}) begin
      $display("FAIL left_edge_hold: x=%0d spd=%0d al=%0b ar=%0b want x=40 spd=1 al=1 ar=0",
               paddle_x, speed, at_left, at_right);
      fails++;
    end
    checks++;
  endtask

  task automatic test_reverse();
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 2, 20);
    if ({paddle_x, speed} !== {10'd309, 4'd3}) begin
      $display("FAIL reverse_pre: x=%0d spd=%0d want x=309 spd=3", paddle_x, speed);
      fails++;
    end
    checks++;
    cycle(1, 1, 20);
    if ({paddle_x, speed} !== {10'd308, 4'd1}) begin
      $display("FAIL reverse_post: x=%0d spd=%0d want x=308 spd=1", paddle_x, speed);
      fails++;
    end
    checks++;
    cycle(1, 1, 20);
    if ({paddle_x, speed} !== {10'd307, 4'd1}) begin
      $display("FAIL reverse_cont: x=%0d spd=%0d want x=307 spd=1", paddle_x, speed);
      fails++;
    end
    checks++;
  endtask

  task automatic test_width_change();
    do_reset();
    for (int i = 0; i < 60; i++) cycle(1, 2, 30);
    if ({paddle_x, at_right} !== {10'd580, 1'b1}) begin
      $display("FAIL width_push: x=%0d ar=%0b want x=580 ar=1", paddle_x, at_right);
      fails++;
    end
    checks++;
    cycle(1, 0, 20);
    if ({paddle_x, speed, at_right} !== {10'd580, 4'd0, 1'b0}) begin
      $display("FAIL width_20: x=%0d spd=%0d ar=%0b want x=580 spd=0 ar=0", paddle_x, speed, at_right);
      fails++;
    end
    checks++;
    cycle(1, 0, 50);
    if ({paddle_x, at_left, at_right} !== {10'd560, 1'b0, 1'b1}) begin
      $display("FAIL width_50: x=%0d al=%0b ar=%0b want x=560 al=0 ar=1", paddle_x, at_left, at_right);
      fails++;
    end
    checks++;
  endtask

  task automatic test_reset_mid_motion();
    do_reset();
    for (int i = 0; i < 12; i++) cycle(1, 2, 20);
    if (speed !== 4'd4) begin
      $display("FAIL midrst_pre: spd=%0d want 4", speed);
      fails++;
    end
    checks++;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    if ({paddle_x, speed, at_left, at_right} !== {10'd295, 4'd0, 1'b0, 1'b0}) begin
      $display("FAIL midrst_async: x=%0d spd=%0d al=%0b ar=%0b want x=295 spd=0 al=0 ar=0",
               paddle_x, speed, at_left, at_right);
      fails++;
    end
    checks++;
    #1 rst = 1'b1;
    model_reset();
    cycle(1, 2, 20);
    if ({paddle_x, speed} !== {10'd296, 4'd1}) begin
      $display("FAIL midrst_first_tick: x=%0d spd=%0d want x=296 spd=1", paddle_x, speed);
      fails++;
    end
    checks++;
  endtask

  task automatic test_tick_hold();
    logic [15:0] snap;
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, 1, 20);
    snap = {paddle_x, speed, at_left, at_right};
    for (int i = 0; i < 10; i++) begin
      cycle(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 127)));
      if ({paddle_x, speed, at_left, at_right} !== snap) begin
        $display("FAIL tick_hold[%0d]: got %h want %h", i, {paddle_x, speed, at_left, at_right}, snap);
        fails++;
      end
      checks++;
    end
  endtask

  task automatic test_random();
    int c, w;
    do_reset();
    c = 0; w = 20;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) c = int'($urandom_range(0, 3));
      if ($urandom_range(0, 40) == 0) w = int'($urandom_range(0, 127));
      cycle(bit'($urandom_range(0, 3) != 0), c, w);
      if ({paddle_x, speed, at_left, at_right} !== {10'(m_x), 4'(m_spd), m_al, m_ar}) begin
        $display("FAIL random[%0d]: x=%0d spd=%0d al=%0b ar=%0b want x=%0d spd=%0d al=%0b ar=%0b",
                 i, paddle_x, speed, at_left, at_right, m_x, m_spd, m_al, m_ar);
        fails++;
      end
      checks++;
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    model_reset();
    test_reset();
    test_accel();
    test_left_edge();
    test_reverse();
    test_width_change();
    test_reset_mid_motion();
    test_tick_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
